// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
//   Memory-side sequencer that turns one 32-bit vector load/store into four
//   byte beats on an 8-bit synchronous memory. Lane 0 (bits [31:24]) lives at
//   the base address, lane 3 (bits [7:0]) at base+3; addresses wrap.
//   Optional feature macro: VMS_ADDR_CHECK_EN. When it is defined, a request
//   whose lanes would run past the top of memory is consumed without memory
//   traffic and answered with a one-cycle err pulse. When it is undefined,
//   addresses wrap and err is tied low.
module vector_mem_sequencer #(
    parameter int ADDR_W = 8,
    parameter int LANE_W = 8,
    parameter int LANES  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_store,
    input  logic [ADDR_W-1:0]         req_base,
    input  logic [LANES*LANE_W-1:0]   req_wdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LANE_W-1:0]         mem_wdata,
    output logic                      mem_wren,
    output logic                      mem_rden,
    input  logic [LANE_W-1:0]         mem_rdata,
    output logic [LANES*LANE_W-1:0]   ld_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int VEC_W = LANES * LANE_W;
    localparam int RB_W  = (LANES - 1) * LANE_W;
    localparam int K_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ST_BEAT  = 3'd1,
        S_LD_BEAT  = 3'd2,
        S_LD_DRAIN = 3'd3,
        S_DONE     = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    state_t             state_r;
    logic [K_W-1:0]     k_r;        // lane index currently on the memory bus
    logic [VEC_W-1:0]   sdata_r;    // store lanes not yet issued, next lane in the top byte
    logic [RB_W-1:0]    rbuf_r;     // load lanes captured so far, oldest in the top byte
    logic               accept_s;

`ifdef VMS_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] MAX_BASE = (ADDR_W+1)'((1 << ADDR_W) - LANES);
    logic err_r;
    logic reject_s;

    // True when the last lane of a vector at this base would run past the top of memory.
    function automatic logic base_out_of_range(input logic [ADDR_W-1:0] base);
        return ({1'b0, base} > MAX_BASE);
    endfunction

    // Range check on the request currently offered.
    always_comb begin
        reject_s = 1'b0;
        if (accept_s) begin
            reject_s = base_out_of_range(req_base);
        end else begin
            reject_s = 1'b0;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign accept_s = req_valid & req_ready;

    // Sequencer FSM: all memory-side and handshake outputs are registered here.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            k_r       <= {K_W{1'b0}};
            sdata_r   <= {VEC_W{1'b0}};
            rbuf_r    <= {RB_W{1'b0}};
            req_ready <= 1'b1;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {LANE_W{1'b0}};
            mem_wren  <= 1'b0;
            mem_rden  <= 1'b0;
            ld_data   <= {VEC_W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef VMS_ADDR_CHECK_EN
            err_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
`ifdef VMS_ADDR_CHECK_EN
                    err_r <= 1'b0;
`endif
                    if (accept_s) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        k_r       <= {K_W{1'b0}};
`ifdef VMS_ADDR_CHECK_EN
                        if (reject_s) begin
                            // Request is consumed, but no beats go to memory.
                            err_r   <= 1'b1;
                            state_r <= S_ERR;
                        end else begin
`else
                        begin
`endif
                            mem_addr  <= req_base;
                            mem_wdata <= req_wdata[VEC_W-1 -: LANE_W];
                            sdata_r   <= req_wdata << LANE_W;
                            mem_wren  <= req_store;
                            mem_rden  <= ~req_store;
                            state_r   <= req_store ? S_ST_BEAT : S_LD_BEAT;
                        end
                    end
                end
                S_ST_BEAT: begin
                    if (k_r == LAST_K) begin
                        mem_wren <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= S_DONE;
                    end else begin
                        k_r       <= k_r + K_W'(1);
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wdata <= sdata_r[VEC_W-1 -: LANE_W];
                        sdata_r   <= sdata_r << LANE_W;
                    end
                end
                S_LD_BEAT: begin
                    // Read data trails the address by one cycle, so lane k-1 arrives now.
                    if (k_r != {K_W{1'b0}}) begin
                        rbuf_r <= (rbuf_r << LANE_W) | RB_W'(mem_rdata);
                    end
                    if (k_r == LAST_K) begin
                        mem_rden <= 1'b0;
                        state_r  <= S_LD_DRAIN;
                    end else begin
                        k_r      <= k_r + K_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                S_LD_DRAIN: begin
                    // Last lane arrives; publish the whole word in one update.
                    ld_data <= {rbuf_r, mem_rdata};
                    done    <= 1'b1;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= S_IDLE;
                end
`ifdef VMS_ADDR_CHECK_EN
                S_ERR: begin
                    err_r     <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= S_IDLE;
                end
`endif
                default: begin
                    mem_wren  <= 1'b0;
                    mem_rden  <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Testbench for vector_mem_sequencer: directed vectors, scoreboard queue of
// expected memory beats / completions, and an independent negedge monitor.
module tb_vector_mem_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [7:0]  req_base = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic        mem_rden;
    logic [7:0]  mem_rdata = 8'h00;
    logic [31:0] ld_data;
    logic        busy;
    logic        done;
    logic        err;

    vector_mem_sequencer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_base(req_base), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rden(mem_rden), .mem_rdata(mem_rdata),
        .ld_data(ld_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // Synchronous byte memory: q is valid one cycle after the address.
    logic [7:0] mem [0:255];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    localparam int K_WR = 0, K_RD = 1, K_DONE = 2, K_ERR = 3;
    typedef struct {
        int          kind;
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int kind, input int c, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_cycle", 32'(cyc), 32'(e.cyc));
            if (e.kind == K_WR || e.kind == K_RD) check("mem_addr", {24'h0, a}, {24'h0, e.addr});
            if (e.kind == K_WR || e.kind == K_DONE) check("data", d, e.data);
        end
    endtask

    // Monitor: compares every DUT-presented event against the scoreboard.
    always @(negedge clock) begin
        if (mem_wren && mem_rden) check("wren_rden_exclusive", 32'd1, 32'd0);
        if (done && !busy) check("busy_during_done", 32'd0, 32'd1);
        if (mem_wren)       observe(K_WR, mem_addr, {24'h0, mem_wdata});
        else if (mem_rden)  observe(K_RD, mem_addr, 32'h0);
        else if (done)      observe(K_DONE, 8'h00, ld_data);
        else if (err)       observe(K_ERR, 8'h00, 32'h0);
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!busy) begin ok = 1'b1; break; end
        end
        check("idle_timeout", {31'h0, ok}, 32'd1);
    endtask

    task automatic push_op(input int a, input logic st, input logic [7:0] base,
                           input logic [31:0] wd, input logic [31:0] exp_ld);
        for (int k = 0; k < 4; k++) begin
            if (st) push(K_WR, a + k, 8'(base + k), {24'h0, wd[31 - 8*k -: 8]});
            else    push(K_RD, a + k, 8'(base + k), 32'h0);
        end
        push(K_DONE, st ? a + 4 : a + 5, 8'h00, exp_ld);
    endtask

    task automatic run_op(input logic st, input logic [7:0] base, input logic [31:0] wd,
                          input logic [31:0] exp_ld, input bit exp_err);
        int a;
        @(negedge clock);
        req_valid = 1'b1; req_store = st; req_base = base; req_wdata = wd;
        @(posedge clock); #1;
        a = cyc;
        req_valid = 1'b0;
        if (exp_err) push(K_ERR, a, 8'h00, 32'h0);
        else         push_op(a, st, base, wd, exp_ld);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03; mem[8'h23] = 8'h04;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_err", {31'h0, err}, 32'd0);
        check("rst_wren", {31'h0, mem_wren}, 32'd0);
        check("rst_rden", {31'h0, mem_rden}, 32'd0);
        check("rst_ld_data", ld_data, 32'h0);
        reset = 1'b1;

        // 1: store DEADBEEF at 0x10
        run_op(1'b1, 8'h10, 32'hDEADBEEF, 32'h0000_0000, 1'b0);
        check("st1_mem13", {24'h0, mem[8'h13]}, 32'h0000_00EF);
        // 2: load from preloaded 0x20
        run_op(1'b0, 8'h20, 32'h0, 32'h0102_0304, 1'b0);
        check("ld2_ld_data", ld_data, 32'h0102_0304);
        // 6: store then load same base; store leaves ld_data alone
        run_op(1'b1, 8'h50, 32'hCAFEF00D, 32'h0102_0304, 1'b0);
        check("st6_ld_hold", ld_data, 32'h0102_0304);
        run_op(1'b0, 8'h50, 32'h0, 32'hCAFEF00D, 1'b0);
        // 5: load at the top of memory
`ifdef VMS_ADDR_CHECK_EN
        run_op(1'b0, 8'hFE, 32'h0, 32'h0, 1'b1);
        check("ld5_ld_hold", ld_data, 32'hCAFEF00D);
`else
        run_op(1'b0, 8'hFE, 32'h0, 32'h1122_3344, 1'b0);
        check("ld5_wrap", ld_data, 32'h1122_3344);
`endif

        // 3: request held during a store, then a load becomes the pending request
        @(negedge clock);
        req_valid = 1'b1; req_store = 1'b1; req_base = 8'h30; req_wdata = 32'h1234_5678;
        @(posedge clock); #1;
        a = cyc;
`ifdef VMS_ADDR_CHECK_EN
        push_op(a, 1'b1, 8'h30, 32'h1234_5678, 32'hCAFEF00D);
`else
        push_op(a, 1'b1, 8'h30, 32'h1234_5678, 32'h1122_3344);
`endif
        req_store = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clock);
            check("hold_req_ready_low", {31'h0, req_ready}, 32'd0);
            check("hold_busy", {31'h0, busy}, 32'd1);
        end
        @(negedge clock);
        check("hold_ready_again", {31'h0, req_ready}, 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        push_op(a + 6, 1'b0, 8'h30, 32'h0, 32'h1234_5678);
        wait_idle();
        check("b2b_ld_data", ld_data, 32'h1234_5678);

        // 4: reset during the second store beat
        @(negedge clock);
        req_valid = 1'b1; req_store = 1'b1; req_base = 8'h40; req_wdata = 32'hA1B2_C3D4;
        @(posedge clock); #1;
        a = cyc;
        req_valid = 1'b0;
        push(K_WR, a, 8'h40, 32'h0000_00A1);
        push(K_WR, a + 1, 8'h41, 32'h0000_00B2);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("rst_mid_ready", {31'h0, req_ready}, 32'd1);
        check("rst_mid_wren", {31'h0, mem_wren}, 32'd0);
        check("rst_mid_busy", {31'h0, busy}, 32'd0);
        check("rst_mid_ld_clr", ld_data, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        check("rst_mid_mem40", {24'h0, mem[8'h40]}, 32'h0000_00A1);
        check("rst_mid_mem41", {24'h0, mem[8'h41]}, 32'h0000_00B2);
        check("rst_mid_mem42", {24'h0, mem[8'h42]}, 32'h0000_0000);
        run_op(1'b0, 8'h40, 32'h0, 32'hA1B2_0000, 1'b0);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
